// File: rtl/risc_v_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes and datapath select codes.
package risc_v_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/risc_v_alu_decoder.sv
// Combinational ALU control decode: fixed add/sub, or funct3/funct7 decode for R/I-type execute.
module risc_v_alu_decoder
  import risc_v_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/risc_v_mc_controller.sv
// Multicycle RV32I main control FSM; outputs are decoded from state (plus zero/funct/op).
// Optional RV_MC_MEM_READY_EN adds mem_ready to stall FETCH/MEMREAD/MEMWRITE.
module risc_v_mc_controller
  import risc_v_pkg::*;
#(
  parameter bit RESET_TO_FETCH = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef RV_MC_MEM_READY_EN
  input  logic       mem_ready,
`endif
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       instr_retired,
  output logic       illegal_instr
);

  state_t     r_state;
  logic       r_idle_done;
  logic       w_mem_ready;
  logic [1:0] w_alu_op;

`ifdef RV_MC_MEM_READY_EN
  assign w_mem_ready = mem_ready;
`else
  assign w_mem_ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idle_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (RESET_TO_FETCH || r_idle_done) r_state <= S_FETCH;
          r_idle_done <= 1'b1;
        end
        S_FETCH:   if (w_mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_R:              r_state <= S_EXECR;
            OP_I:              r_state <= S_EXECI;
            OP_BRANCH:         r_state <= S_BEQ;
            OP_JAL:            r_state <= S_JAL;
            default:           r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (w_mem_ready) r_state <= S_MEMWB;
        S_MEMWRITE: if (w_mem_ready) r_state <= S_FETCH;
        S_EXECR, S_EXECI, S_JAL:    r_state <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BEQ:    r_state <= S_FETCH;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RD2;
    w_alu_op      = ALUOP_ADD;
    reg_write     = 1'b0;
    instr_retired = 1'b0;
    illegal_instr = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_write   = w_mem_ready;
        pc_write   = w_mem_ready;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        illegal_instr = !(op == OP_LOAD || op == OP_STORE || op == OP_R ||
                          op == OP_I || op == OP_BRANCH || op == OP_JAL);
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src    = RES_DATA;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      // Write strobe stays up across stalls; retire only when the access completes.
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write     = 1'b1;
        instr_retired = w_mem_ready;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        w_alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        w_alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = SRCA_RD1;
        w_alu_op      = ALUOP_SUB;
        pc_write      = zero;
        instr_retired = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign imm_src = imm_src_of(op);

  risc_v_alu_decoder u_alu_dec (
    .alu_op      (w_alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_risc_v_mc_controller.sv
// Self-checking bench: each instruction is modelled as its sequence of datapath phases.
module tb_risc_v_mc_controller;

  typedef struct packed {
    logic       pcw;
    logic       adrs;
    logic       memw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       rw;
    logic       ret;
    logic       ill;
  } ctl_t;

  typedef enum int {
    P_IDLE, P_FETCH, P_DECODE, P_ADDR, P_LOADRD, P_LOADWB,
    P_STORE, P_EXEC_R, P_EXEC_I, P_WB, P_BR, P_JUMP
  } phase_e;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
`ifdef RV_MC_MEM_READY_EN
  logic       mem_ready_v;
`endif
  logic       pc_write, adr_src, mem_write, ir_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       reg_write, instr_retired, illegal_instr;

  int n_cmp = 0;
  int n_bad = 0;

  risc_v_mc_controller dut (
    .clk           (clk),
    .reset         (reset),
`ifdef RV_MC_MEM_READY_EN
    .mem_ready     (mem_ready_v),
`endif
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_control   (alu_control),
    .imm_src       (imm_src),
    .reg_write     (reg_write),
    .instr_retired (instr_retired),
    .illegal_instr (illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit known_op(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
  endfunction

  function automatic int n_phases(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011: return 4;
      7'b0110011: return 4;
      7'b0010011: return 4;
      7'b1100011: return 3;
      7'b1101111: return 4;
      default:    return 2;
    endcase
  endfunction

  function automatic phase_e phase_at(input logic [6:0] o, input int k);
    if (k == 0) return P_FETCH;
    if (k == 1) return P_DECODE;
    case (o)
      7'b0000011: return (k == 2) ? P_ADDR : (k == 3) ? P_LOADRD : P_LOADWB;
      7'b0100011: return (k == 2) ? P_ADDR : P_STORE;
      7'b0110011: return (k == 2) ? P_EXEC_R : P_WB;
      7'b0010011: return (k == 2) ? P_EXEC_I : P_WB;
      7'b1100011: return P_BR;
      default:    return (k == 2) ? P_JUMP : P_WB;
    endcase
  endfunction

  function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic f7, input logic op5);
    case (f3)
      3'd0:    return (f7 && op5) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd4:    return 3'd4;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic ctl_t model(input phase_e ph, input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z, input logic rdy);
    ctl_t e = '0;
    e.imm = (o == 7'b0100011) ? 2'd1 : (o == 7'b1100011) ? 2'd2 : (o == 7'b1101111) ? 2'd3 : 2'd0;
    case (ph)
      P_FETCH:  begin e.irw = rdy; e.pcw = rdy; e.sb = 2'd2; e.rs = 2'd2; end
      P_DECODE: begin e.sa = 2'd1; e.sb = 2'd1; e.ill = !known_op(o); end
      P_ADDR:   begin e.sa = 2'd2; e.sb = 2'd1; end
      P_LOADRD: e.adrs = 1'b1;
      P_LOADWB: begin e.rs = 2'd1; e.rw = 1'b1; e.ret = 1'b1; end
      P_STORE:  begin e.adrs = 1'b1; e.memw = 1'b1; e.ret = rdy; end
      P_EXEC_R: begin e.sa = 2'd2; e.alu = alu_ref(f3, f7, o[5]); end
      P_EXEC_I: begin e.sa = 2'd2; e.sb = 2'd1; e.alu = alu_ref(f3, f7, o[5]); end
      P_WB:     begin e.rw = 1'b1; e.ret = 1'b1; end
      P_BR:     begin e.sa = 2'd2; e.alu = 3'd1; e.pcw = z; e.ret = 1'b1; end
      P_JUMP:   begin e.sa = 2'd1; e.sb = 2'd2; e.pcw = 1'b1; end
      default:  ;
    endcase
    return e;
  endfunction

  function automatic ctl_t observed();
    return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
            alu_control, imm_src, reg_write, instr_retired, illegal_instr};
  endfunction

  task automatic chk(input string tag, input phase_e ph, input logic rdy);
    ctl_t exp_v;
    ctl_t obs_v;
    exp_v = model(ph, op, funct3, funct7b5, zero, rdy);
    obs_v = observed();
    n_cmp++;
    assert (obs_v === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s phase=%0d op=%b observed=%h expected=%h", tag, ph, op, obs_v, exp_v);
    end
  endtask

  // zsel: 0/1 forces the ALU zero flag, 2 randomizes it every cycle.
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int nmax, input int zsel);
    int n;
    n = n_phases(o);
    if (nmax < n) n = nmax;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        op = o; funct3 = f3; funct7b5 = f7;
      end
      zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      #1;
      chk(tag, phase_at(o, k), 1'b1);
    end
  endtask

  task automatic release_and_check();
    @(negedge clk);
    reset = 1'b1;
    #1 chk("release_idle0", P_IDLE, 1'b1);
    @(negedge clk);
    #1 chk("release_idle1", P_IDLE, 1'b1);
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [6:0] o;
    int         pick;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
`ifdef RV_MC_MEM_READY_EN
    mem_ready_v = 1'b1;
`endif
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 chk("reset_async", P_IDLE, 1'b1);
    repeat (3) begin
      @(negedge clk);
      #1 chk("reset_hold", P_IDLE, 1'b1);
    end
    release_and_check();

    run_instr("lw",         7'b0000011, 3'd2, 1'b0, 99, 2);
    run_instr("sw",         7'b0100011, 3'd2, 1'b0, 99, 2);
    run_instr("r_sub",      7'b0110011, 3'd0, 1'b1, 99, 2);
    run_instr("i_addi",     7'b0010011, 3'd0, 1'b1, 99, 2);
    run_instr("r_and",      7'b0110011, 3'd7, 1'b0, 99, 2);
    run_instr("beq_taken",  7'b1100011, 3'd0, 1'b0, 99, 1);
    run_instr("beq_nt",     7'b1100011, 3'd0, 1'b0, 99, 0);
    run_instr("illegal",    7'b1111111, 3'd0, 1'b0, 99, 2);
    run_instr("jal",        7'b1101111, 3'd0, 1'b0, 99, 2);

    // Abandon a JAL in its jump step and restart from reset.
    run_instr("jal_part",   7'b1101111, 3'd0, 1'b0, 3, 2);
    #1 reset = 1'b0;
    #1 chk("midjal_reset_async", P_IDLE, 1'b1);
    repeat (3) begin
      @(negedge clk);
      #1 chk("midjal_reset_hold", P_IDLE, 1'b1);
    end
    release_and_check();
    run_instr("after_reset_lw", 7'b0000011, 3'd0, 1'b0, 99, 2);

`ifdef RV_MC_MEM_READY_EN
    begin
      phase_e     seq [8];
      logic [7:0] rdyv;
      seq[0] = P_FETCH; seq[1] = P_FETCH; seq[2] = P_FETCH; seq[3] = P_DECODE;
      seq[4] = P_ADDR;  seq[5] = P_STORE; seq[6] = P_STORE; seq[7] = P_STORE;
      rdyv = 8'b10011100;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (i == 0) begin
          op = 7'b0100011; funct3 = 3'd2; funct7b5 = 1'b0;
        end
        mem_ready_v = rdyv[i];
        zero = 1'($urandom_range(0, 1));
        #1 chk("sw_stall", seq[i], rdyv[i]);
      end
      mem_ready_v = 1'b1;
    end
`endif

    for (int t = 0; t < 300; t++) begin
      pick = $urandom_range(0, 7);
      if (pick < 6) o = ops[pick];
      else begin
        o = 7'($urandom);
        while (known_op(o)) o = 7'($urandom);
      end
      run_instr("random", o, 3'($urandom), 1'($urandom), 99, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
